// File: rtl/machine_timer_unit_if.sv
// rtl/machine_timer_unit_if.sv - word-wide register bus into the machine timer
interface machine_timer_unit_if;
  logic        wrEnable;
  logic [3:0]  wrOffset;
  logic [31:0] wrData;
  logic        rdEnable;
  logic [3:0]  rdOffset;
  logic [31:0] rdData;
  logic        rdValid;

  modport master (
    output wrEnable, wrOffset, wrData, rdEnable, rdOffset,
    input  rdData, rdValid
  );

  modport slave (
    input  wrEnable, wrOffset, wrData, rdEnable, rdOffset,
    output rdData, rdValid
  );
endinterface

// File: rtl/machine_timer_unit.sv
// rtl/machine_timer_unit.sv - RISC-V mtime/mtimecmp timer with prescaler and level interrupt
module machine_timer_unit #(
  parameter int PRESCALE = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        timerStop,
  machine_timer_unit_if.slave         bus,
  output logic                        reqTimerInterrupt
);

  localparam logic [15:0] PRESCALE_MAX = 16'(PRESCALE - 1);

  logic [15:0] prescaler;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;

  logic        tick;
  logic        wrAligned;
  logic        rdAligned;
  logic [15:0] prescalerNext;
  logic [63:0] mtimeNext;
  logic [63:0] mtimecmpNext;
  logic [31:0] rdWord;

  assign tick      = !timerStop && (prescaler == PRESCALE_MAX);
  assign wrAligned = bus.wrEnable && (bus.wrOffset[1:0] == 2'b00);
  assign rdAligned = bus.rdOffset[1:0] == 2'b00;

  always_comb begin
    prescalerNext = prescaler;
    if (!timerStop) begin
      prescalerNext = tick ? 16'd0 : prescaler + 16'd1;
    end
  end

  // A software write to either mtime half overrides the tick for that cycle.
  always_comb begin
    mtimeNext    = mtime;
    mtimecmpNext = mtimecmp;
    if (tick) begin
      mtimeNext = mtime + 64'd1;
    end
    if (wrAligned) begin
      case (bus.wrOffset[3:2])
        2'd0:    mtimeNext    = {mtime[63:32], bus.wrData};
        2'd1:    mtimeNext    = {bus.wrData, mtime[31:0]};
        2'd2:    mtimecmpNext = {mtimecmp[63:32], bus.wrData};
        default: mtimecmpNext = {bus.wrData, mtimecmp[31:0]};
      endcase
    end
  end

  always_comb begin
    rdWord = 32'd0;
    if (rdAligned) begin
      case (bus.rdOffset[3:2])
        2'd0:    rdWord = mtime[31:0];
        2'd1:    rdWord = mtime[63:32];
        2'd2:    rdWord = mtimecmp[31:0];
        default: rdWord = mtimecmp[63:32];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prescaler         <= 16'd0;
      mtime             <= 64'd0;
      mtimecmp          <= 64'hFFFF_FFFF_FFFF_FFFF;
      bus.rdData        <= 32'd0;
      bus.rdValid       <= 1'b0;
      reqTimerInterrupt <= 1'b0;
    end else begin
      prescaler         <= prescalerNext;
      mtime             <= mtimeNext;
      mtimecmp          <= mtimecmpNext;
      bus.rdValid       <= bus.rdEnable;
      reqTimerInterrupt <= mtime >= mtimecmp;
      if (bus.rdEnable) begin
        bus.rdData <= rdWord;
      end
    end
  end

endmodule

// File: tb/tb_machine_timer_unit.sv
// tb/tb_machine_timer_unit.sv - directed self-checking bench for machine_timer_unit
module tb_machine_timer_unit;

  logic clk = 1'b0;
  logic rst1, rst4;
  logic stop1, stop4;
  logic irq1, irq4;
  int   checks = 0;
  int   failures = 0;

  machine_timer_unit_if bus1 ();
  machine_timer_unit_if bus4 ();

  machine_timer_unit #(.PRESCALE(1)) u1 (
    .clk(clk), .rst(rst1), .timerStop(stop1), .bus(bus1), .reqTimerInterrupt(irq1)
  );

  machine_timer_unit #(.PRESCALE(4)) u4 (
    .clk(clk), .rst(rst4), .timerStop(stop4), .bus(bus4), .reqTimerInterrupt(irq4)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel4, input logic we, input logic [3:0] wo,
                       input logic [31:0] wd, input logic re, input logic [3:0] ro);
    if (sel4) begin
      bus4.wrEnable = we; bus4.wrOffset = wo; bus4.wrData = wd;
      bus4.rdEnable = re; bus4.rdOffset = ro;
    end else begin
      bus1.wrEnable = we; bus1.wrOffset = wo; bus1.wrData = wd;
      bus1.rdEnable = re; bus1.rdOffset = ro;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic resetUnit(input bit sel4);
    drive(sel4, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0);
    if (sel4) rst4 = 1'b0; else rst1 = 1'b0;
    cyc();
    cyc();
    if (sel4) rst4 = 1'b1; else rst1 = 1'b1;
  endtask

  initial begin
    stop1 = 1'b0;
    stop4 = 1'b0;
    rst4  = 1'b1;
    resetUnit(1'b1);

    // 1: reset held 3 cycles with write and read strobes active
    rst1 = 1'b0;
    drive(1'b0, 1'b1, 4'h0, 32'h55, 1'b1, 4'h0);
    cyc(); cyc(); cyc();
    chk("rst_rdValid", bus1.rdValid, 0);
    chk("rst_irq", irq1, 0);
    chk("rst_rdData", bus1.rdData, 0);
    rst1 = 1'b1;
    drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 4'hC);
    cyc();
    chk("rst_cmp_hi", bus1.rdData, 32'hFFFF_FFFF);
    chk("rst_cmp_hi_valid", bus1.rdValid, 1);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 4'h4);
    cyc();
    chk("rst_mtime_hi", bus1.rdData, 0);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 4'h0);
    cyc();
    chk("rst_mtime_lo", bus1.rdData, 2);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0);
    cyc();
    chk("idle_rdValid", bus1.rdValid, 0);
    chk("idle_rdData_hold", bus1.rdData, 2);

    // 2: PRESCALE=4, compare at 8, interrupt one cycle after mtime reaches 8
    resetUnit(1'b1);
    drive(1'b1, 1'b1, 4'hC, 32'h0, 1'b0, 4'h0);
    cyc();
    drive(1'b1, 1'b1, 4'h8, 32'h8, 1'b0, 4'h0);
    cyc();
    for (int k = 3; k <= 40; k++) begin
      drive(1'b1, 1'b0, 4'h0, 32'h0, (k == 33), 4'h0);
      cyc();
      chk($sformatf("pre_irq_%0d", k), irq4, (k >= 33) ? 64'd1 : 64'd0);
      if (k == 33) chk("pre_mtime_at_8", bus4.rdData, 8);
    end

    // 3: carry into hi and 64-bit wrap with cmp = FFFF_FFFF_0000_0000
    resetUnit(1'b0);
    drive(1'b0, 1'b1, 4'h8, 32'h0, 1'b0, 4'h0);
    cyc();
    chk("wrap_irq_e1", irq1, 0);
    drive(1'b0, 1'b1, 4'h4, 32'hFFFF_FFFF, 1'b0, 4'h0);
    cyc();
    chk("wrap_irq_e2", irq1, 0);
    drive(1'b0, 1'b1, 4'h0, 32'hFFFF_FFFE, 1'b0, 4'h0);
    cyc();
    chk("wrap_irq_e3", irq1, 1);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 4'h0);
    cyc();
    chk("wrap_lo_fffe", bus1.rdData, 32'hFFFF_FFFE);
    chk("wrap_irq_e4", irq1, 1);
    cyc();
    chk("wrap_lo_ffff", bus1.rdData, 32'hFFFF_FFFF);
    chk("wrap_irq_e5", irq1, 1);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 4'h4);
    cyc();
    chk("wrap_hi_zero", bus1.rdData, 0);
    chk("wrap_irq_clear", irq1, 0);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 4'h0);
    cyc();
    chk("wrap_lo_after", bus1.rdData, 1);

    // 4: write to mtime_lo on a tick cycle with lo all-ones: no carry
    drive(1'b0, 1'b1, 4'h4, 32'h0000_0ABC, 1'b0, 4'h0);
    cyc();
    drive(1'b0, 1'b1, 4'h0, 32'hFFFF_FFFF, 1'b0, 4'h0);
    cyc();
    drive(1'b0, 1'b1, 4'h0, 32'h5, 1'b0, 4'h0);
    cyc();
    drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 4'h0);
    cyc();
    chk("collide_lo", bus1.rdData, 5);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 4'h4);
    cyc();
    chk("collide_hi", bus1.rdData, 32'h0000_0ABC);

    // 5: read-before-write, misaligned read and write
    drive(1'b0, 1'b1, 4'h8, 32'h3, 1'b0, 4'h0);
    cyc();
    drive(1'b0, 1'b1, 4'h8, 32'h9, 1'b1, 4'h8);
    cyc();
    chk("rbw_old", bus1.rdData, 3);
    drive(1'b0, 1'b1, 4'h9, 32'h7, 1'b1, 4'h8);
    cyc();
    chk("rbw_new", bus1.rdData, 9);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 4'h8);
    cyc();
    chk("misaligned_wr_ignored", bus1.rdData, 9);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 4'h2);
    cyc();
    chk("misaligned_rd_data", bus1.rdData, 0);
    chk("misaligned_rd_valid", bus1.rdValid, 1);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b1, 4'h8);
    cyc();
    chk("reread_cmp_lo", bus1.rdData, 9);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0);
    cyc();
    chk("hold_valid", bus1.rdValid, 0);
    chk("hold_data", bus1.rdData, 9);

    // 6: timerStop freezes mtime and prescaler for 10 cycles at mtime=100
    resetUnit(1'b1);
    drive(1'b1, 1'b1, 4'h0, 32'd100, 1'b0, 4'h0);
    cyc();
    drive(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0);
    cyc();
    for (int j = 3; j <= 18; j++) begin
      stop4 = (j <= 12);
      drive(1'b1, 1'b0, 4'h0, 32'h0, 1'b1, 4'h0);
      cyc();
      chk($sformatf("stop_mtime_%0d", j), bus4.rdData, (j <= 14) ? 64'd100 : 64'd101);
    end
    stop4 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
